// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache-to-memory busywait protocol: state encoding,
// default geometry/latency constants and the operation type latched per request.
package mem_if_pkg;

  localparam int ADDR_W_DEF      = 6;
  localparam int DATA_W_DEF      = 32;
  localparam int LATENCY_DEF     = 5;
  localparam int BYTES_PER_BLOCK = DATA_W_DEF / 8;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Counter preload so that the access lands exactly LATENCY edges after the sample edge.
  function automatic logic [CNT_W-1:0] latency_preload(input int latency);
    return CNT_W'(latency - 1);
  endfunction

endpackage

// File: rtl/block_mem_array.sv
// Byte-organised backing store with one block-wide write port and one registered
// block-wide read port; blocks are little-endian (lane 0 = lowest byte address).
module block_mem_array #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int BPB    = DATA_W / 8;
  localparam int NBYTES = (2 ** ADDR_W) * BPB;
  localparam int IDX_W  = $clog2(NBYTES);

  // Contents survive reset; only the read register is cleared.
  logic [7:0]        mem [NBYTES];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  function automatic logic [IDX_W-1:0] byte_idx(input logic [ADDR_W-1:0] a, input int lane);
    return IDX_W'(a) * IDX_W'(BPB) + IDX_W'(lane);
  endfunction

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BPB; b++) begin
        mem[byte_idx(addr, b)] <= wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int b = 0; b < BPB; b++) begin
      rd_word[8*b +: 8] = mem[byte_idx(addr, b)];
    end
    rdata_d = re ? rd_word : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/block_mem_responder.sv
// Memory-side responder: latches a block request, waits LATENCY edges, performs the
// access, then drops busywait for one DONE cycle before accepting the next request.
module block_mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              busywait
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy;
  logic              mem_we;
  logic              mem_re;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy    = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Combinational stall so the cache holds in the very cycle it asks.
        busy = read | write;
        if (read | write) begin
          addr_d  = address;
          wdata_d = writedata;
          op_d    = write ? OP_WRITE : OP_READ;
          cnt_d   = latency_preload(LATENCY);
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          mem_we  = (op_q == OP_WRITE);
          mem_re  = (op_q == OP_READ);
          state_d = DONE;
        end
      end
      DONE: begin
        // Request lines are still high here as the cache releases them; ignore them.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset drops busywait immediately even if the cache is still holding a request.
  assign busywait = busy & ~RESET;

  block_mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk  (CLK),
    .rst  (RESET),
    .we   (mem_we),
    .re   (mem_re),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(readdata)
  );

endmodule

// File: tb/tb_block_mem_responder.sv
// Directed plus randomized check of the block responder against a byte-array model.
module tb_block_mem_responder;
  import mem_if_pkg::*;

  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 32;
  localparam int LATENCY = 5;
  localparam int BPB     = DATA_W / 8;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              busywait;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]        mem_m [(2**ADDR_W)*BPB];
  logic [DATA_W-1:0] rd_m;
  bit                in_done;

  block_mem_responder #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LATENCY(LATENCY)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .read     (read),
    .write    (write),
    .address  (address),
    .writedata(writedata),
    .readdata (readdata),
    .busywait (busywait)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_load(input int a);
    logic [DATA_W-1:0] r;
    for (int b = 0; b < BPB; b++) r[8*b +: 8] = mem_m[a*BPB + b];
    return r;
  endfunction

  task automatic model_store(input int a, input logic [DATA_W-1:0] d);
    for (int b = 0; b < BPB; b++) mem_m[a*BPB + b] = d[8*b +: 8];
  endtask

  // One transaction; entered and left at #1 after a rising edge.
  task automatic txn(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, input bit scramble);
    int edges;
    read = rd; write = wr; address = a; writedata = d;
    #1;
    if (in_done) begin
      chk("done_ignores_req", {31'b0, busywait}, 32'd0);
      @(posedge CLK); #1;
    end
    chk("request_stall", {31'b0, busywait}, 32'd1);
    @(posedge CLK); #1;
    if (scramble) begin
      address   = ADDR_W'($urandom);
      writedata = $urandom;
    end
    edges = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge CLK); #1;
      if (!busywait) begin
        edges = k;
        break;
      end
    end
    chk("latency_edges", 32'(edges), 32'(LATENCY));
    if (wr) model_store(int'(a), d);
    else    rd_m = model_load(int'(a));
    chk("readdata", readdata, rd_m);
    read = 1'b0; write = 1'b0;
    in_done = 1'b1;
  endtask

  task automatic idle(input int n);
    read = 1'b0; write = 1'b0;
    repeat (n) begin @(posedge CLK); #1; end
    chk("idle_busywait", {31'b0, busywait}, 32'd0);
    in_done = 1'b0;
  endtask

  initial begin
    bit rr, ww;
    for (int i = 0; i < (2**ADDR_W)*BPB; i++) mem_m[i] = 8'h00;
    rd_m = '0; in_done = 1'b0;
    read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    RESET = 1'b1;
    #11 RESET = 1'b0;
    @(posedge CLK); #1;
    chk("reset_busywait", {31'b0, busywait}, 32'd0);
    chk("reset_readdata", readdata, 32'd0);
    chk("reset_state", {30'b0, dut.state_q}, {30'b0, IDLE});

    // Single write, then byte layout
    txn(1'b0, 1'b1, 6'h05, 32'hDEADBEEF, 1'b0);
    idle(1);
    chk("byte20", {24'b0, dut.u_array.mem[20]}, 32'h000000EF);
    chk("byte21", {24'b0, dut.u_array.mem[21]}, 32'h000000BE);
    chk("byte22", {24'b0, dut.u_array.mem[22]}, 32'h000000AD);
    chk("byte23", {24'b0, dut.u_array.mem[23]}, 32'h000000DE);

    // Read-back
    txn(1'b1, 1'b0, 6'h05, 32'h0, 1'b0);
    chk("readback_val", readdata, 32'hDEADBEEF);
    idle(1);

    // Back-to-back traffic
    txn(1'b0, 1'b1, 6'h3F, 32'h01020304, 1'b0);
    txn(1'b1, 1'b0, 6'h3F, 32'h0, 1'b0);
    chk("b2b_read_3f", readdata, 32'h01020304);
    txn(1'b1, 1'b0, 6'h00, 32'h0, 1'b0);
    chk("b2b_read_00", readdata, 32'h00000000);
    idle(2);

    // Simultaneous read+write is a write; readdata unchanged
    txn(1'b1, 1'b1, 6'h0A, 32'hCAFEF00D, 1'b0);
    chk("simul_rd_unchanged", readdata, 32'h00000000);
    txn(1'b1, 1'b0, 6'h0A, 32'h0, 1'b0);
    chk("simul_readback", readdata, 32'hCAFEF00D);
    idle(1);

    // Reset in the middle of a write
    read = 1'b0; write = 1'b1; address = 6'h07; writedata = 32'h11111111;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b1;
    #1;
    chk("reset_mid_busywait", {31'b0, busywait}, 32'd0);
    chk("reset_mid_state", {30'b0, dut.state_q}, {30'b0, IDLE});
    repeat (4) @(posedge CLK);
    write = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    rd_m = '0;
    chk("reset_mid_readdata", readdata, 32'd0);
    @(posedge CLK); #1;
    in_done = 1'b0;
    txn(1'b1, 1'b0, 6'h07, 32'h0, 1'b0);
    chk("reset_write_discarded", readdata, 32'h00000000);

    // Randomized traffic with address/data disturbed after the sample edge
    for (int n = 0; n < 60; n++) begin
      rr = 1'($urandom);
      ww = 1'($urandom);
      if (!rr && !ww) rr = 1'b1;
      txn(rr, ww, ADDR_W'($urandom_range(0, 2**ADDR_W - 1)), $urandom, 1'b1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    for (int n = 0; n < 16; n++) begin
      txn(1'b1, 1'b0, ADDR_W'($urandom_range(0, 2**ADDR_W - 1)), 32'h0, 1'b1);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
